i2c_byte_ctrl: RTL and testbench
================================

# i2c_byte_ctrl

Byte-level I2C master sequencer that drives the bit-level `i2c_phy` command pins. It accepts one byte command at a time over a valid/ready handshake and expands it into an ordered series of single-cycle phy pulses: optional (repeated) start, 8 data bits MSB-first, the ACK bit, and optional stop. It captures read data and the slave ACK. It sits between the register/host front end and `i2c_phy`.

## Interface
- No parameters; bit count (8) and phy state encodings come from `i2c_pkg`.
- Clock and reset: `clk` and `rst`. Reset `rst` is synchronous and active-high; clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller idle, can accept
- `cmd_start`  in  1  issue start (repeated start if bus held) before byte
- `cmd_write`  in  1  write `cmd_data`
- `cmd_read`  in  1  read one byte (exclusive with `cmd_write`)
- `cmd_nack`  in  1  for read: send NACK (1) instead of ACK (0)
- `cmd_stop`  in  1  issue stop after byte
- `cmd_data`  in  8  write byte
- `rd_data`  out  8  last read byte
- `rd_valid`  out  1  one-cycle strobe, `rd_data` updated
- `ack_err`  out  1  slave NACKed last write byte
- `abort`  in  1  release bus immediately
- `phy_start_bit`, `phy_stop_bit`, `phy_write_bit`, `phy_read_bit`, `phy_release_bus`  out  1 each  registered one-cycle command pulses
- `phy_tx_data`  out  1  bit to write
- `phy_rx_data`  in  1  phy sampled SDA
- `phy_state`  in  5  phy state (IDLE=0, ACTIVE=1)
- `bus_control`  in  1  phy owns bus

## Operation
- States: C_IDLE, C_START, C_WAIT_START, C_BIT, C_WAIT_BIT, C_ACK, C_WAIT_ACK, C_STOP, C_WAIT_STOP.
- `cmd_ready` = (state == C_IDLE). On `cmd_valid && cmd_ready`, latch all cmd fields and load the shift register. Clear `ack_err`. Clear bit counter to 7.
- Next state after accept:
  - If `cmd_start`, go to C_START.
  - Else if a data op is present, go to C_BIT.
  - Else if `cmd_stop`, go to C_STOP.
  - Else return to C_IDLE (no-op).
- Issue rule: a pulse is issued only when `phy_state` is IDLE (start from idle bus) or ACTIVE (all other commands). Otherwise the controller holds in the issue state.
- C_START: pulse `phy_start_bit`. Then wait for `phy_state == ACTIVE`.
- C_BIT, write: `phy_tx_data` = shift[7], pulse `phy_write_bit`.
- C_BIT, read: pulse `phy_read_bit`.
- In C_WAIT_BIT, on completion:
  - Read: shift in `phy_rx_data` at the LSB.
  - Decrement the counter.
  - After bit 0 completes, go to C_ACK; otherwise go back to C_BIT.
- C_ACK, write: pulse `phy_read_bit`. On completion, `ack_err` ← `phy_rx_data`.
- C_ACK, read: `phy_tx_data` = `cmd_nack`, pulse `phy_write_bit`. On completion, `rd_data` ← shift and pulse `rd_valid`.
- After ACK:
  - Go to C_STOP if `cmd_stop` && `bus_control`.
  - Otherwise go to C_IDLE.
- C_STOP: pulse `phy_stop_bit`. Wait for `phy_state == IDLE`.
- A slave NACK does not cancel a requested stop.
- `cmd_stop` with `bus_control == 0` skips the stop.
- `cmd_write && cmd_read` together: treat as read.

## Timing
- Reset values:
  - State C_IDLE; `cmd_ready` = 1.
  - All `phy_*` pulses 0 and `phy_tx_data` 1.
  - `rd_data` 0x00, `rd_valid` 0, `ack_err` 0.
- Command pulses last exactly one cycle. The cycle after a pulse is a guard cycle in which `phy_state` is ignored. Completion is the first later cycle with the target state.
- Latency from accept to the first phy pulse is 1 cycle. The phy then governs bit time.
- `rd_valid` fires the cycle after read-ACK completion.
- `ack_err` updates the cycle after write-ACK completion. It holds until the next accept.
- `abort`:
  - Has priority in any state.
  - Next cycle: `phy_release_bus` = 1 for one cycle, all other pulses 0, state C_IDLE, latched command discarded, no `rd_valid`.
  - `cmd_ready` = 1 the cycle after that.
- `rst` mid-operation: all registers go to reset values on the next edge. The phy is reset by the same `rst`.
- `cmd_valid` while busy is ignored (no accept).

## Structure
- `i2c_pkg` holds:
  - Phy state localparams (PHY_IDLE=0, PHY_ACTIVE=1, full 5-bit list shared with `i2c_phy`).
  - Controller state encodings.
  - `I2C_BITS` = 8.
- Single module, no sub-modules. The bit counter and shift register are inline.

## Test plan
All scenarios use a behavioural phy model.
- Write byte: start+write 0xA5+stop, slave ACK → `phy_write_bit` ×8 with `phy_tx_data` 1,0,1,0,0,1,0,1; then `phy_read_bit` ×1; then `phy_stop_bit` ×1; `ack_err` = 0; bus IDLE.
- Read byte: read+nack+stop, slave drives 0x3C → `rd_data` = 0x3C, `rd_valid` high 1 cycle, ACK write carries 1, stop issued.
- Slave NACK: start+write 0x50, slave NACK → `ack_err` = 1. With `cmd_stop` = 0, no stop is issued; the next accept clears `ack_err`.
- Repeated start: write without stop, then start+read → `phy_start_bit` issued from ACTIVE with no stop in between.
- Abort after 3 bits of a write → `phy_release_bus` 1 cycle, no further pulses, `cmd_ready` = 1 two cycles after `abort`.
- `rst` asserted mid-read for 1 cycle → all outputs at reset values, `cmd_ready` = 1, no `rd_valid`.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: phy state codes, controller
// states and the command bundles used by the byte sequencer.
package i2c_pkg;

    localparam int I2C_BITS = 8;
    localparam int CNT_W    = $clog2(I2C_BITS);

    // Phy state codes, shared with i2c_phy.
    localparam logic [4:0] PHY_IDLE     = 5'd0;
    localparam logic [4:0] PHY_ACTIVE   = 5'd1;
    localparam logic [4:0] PHY_START_A  = 5'd2;
    localparam logic [4:0] PHY_START_B  = 5'd3;
    localparam logic [4:0] PHY_START_C  = 5'd4;
    localparam logic [4:0] PHY_STOP_A   = 5'd5;
    localparam logic [4:0] PHY_STOP_B   = 5'd6;
    localparam logic [4:0] PHY_STOP_C   = 5'd7;
    localparam logic [4:0] PHY_WR_A     = 5'd8;
    localparam logic [4:0] PHY_WR_B     = 5'd9;
    localparam logic [4:0] PHY_WR_C     = 5'd10;
    localparam logic [4:0] PHY_WR_D     = 5'd11;
    localparam logic [4:0] PHY_RD_A     = 5'd12;
    localparam logic [4:0] PHY_RD_B     = 5'd13;
    localparam logic [4:0] PHY_RD_C     = 5'd14;
    localparam logic [4:0] PHY_RD_D     = 5'd15;
    localparam logic [4:0] PHY_RELEASE  = 5'd16;

    typedef enum logic [3:0] {
        C_IDLE       = 4'd0,
        C_START      = 4'd1,
        C_WAIT_START = 4'd2,
        C_BIT        = 4'd3,
        C_WAIT_BIT   = 4'd4,
        C_ACK        = 4'd5,
        C_WAIT_ACK   = 4'd6,
        C_STOP       = 4'd7,
        C_WAIT_STOP  = 4'd8
    } ctrl_state_t;

    // Latched command; read wins when both ops are set.
    typedef struct packed {
        logic op;
        logic read;
        logic nack;
        logic stop;
    } cmd_t;

    // One-cycle command pulses towards the phy.
    typedef struct packed {
        logic start;
        logic stop;
        logic write;
        logic read;
        logic release_bus;
    } phy_cmd_t;

    function automatic cmd_t pack_cmd(
        input logic wr,
        input logic rd,
        input logic nack,
        input logic stop
    );
        cmd_t c;
        c.op   = wr | rd;
        c.read = rd;
        c.nack = nack;
        c.stop = stop;
        return c;
    endfunction

endpackage

// File: rtl/i2c_byte_ctrl_if.sv
// Host-side command bus of the I2C byte sequencer.
// master = register/host front end, slave = sequencer.
interface i2c_byte_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_start;
    logic       cmd_write;
    logic       cmd_read;
    logic       cmd_nack;
    logic       cmd_stop;
    logic [7:0] cmd_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       ack_err;
    logic       abort;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_write,
        output cmd_read,
        output cmd_nack,
        output cmd_stop,
        output cmd_data,
        output abort,
        input  cmd_ready,
        input  rd_data,
        input  rd_valid,
        input  ack_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_write,
        input  cmd_read,
        input  cmd_nack,
        input  cmd_stop,
        input  cmd_data,
        input  abort,
        output cmd_ready,
        output rd_data,
        output rd_valid,
        output ack_err
    );

endinterface

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: expands one host command
// into start / 8 data bits / ACK / stop pulses for i2c_phy.
module i2c_byte_ctrl
    import i2c_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    i2c_byte_ctrl_if.slave  host,
    output logic            phy_start_bit,
    output logic            phy_stop_bit,
    output logic            phy_write_bit,
    output logic            phy_read_bit,
    output logic            phy_release_bus,
    output logic            phy_tx_data,
    input  logic            phy_rx_data,
    input  logic [4:0]      phy_state,
    input  logic            bus_control
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(I2C_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Pulse cycle plus guard cycle before phy_state counts.
    localparam logic [1:0]       GUARD   = 2'd2;

    ctrl_state_t         state_q;
    ctrl_state_t         state_d;
    cmd_t                cmd_q;
    cmd_t                cmd_d;
    cmd_t                cmd_in;
    phy_cmd_t            pls_q;
    phy_cmd_t            pls_d;
    logic [I2C_BITS-1:0] shift_q;
    logic [I2C_BITS-1:0] shift_d;
    logic [I2C_BITS-1:0] rd_data_q;
    logic [I2C_BITS-1:0] rd_data_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [1:0]          guard_q;
    logic [1:0]          guard_d;
    logic                rd_valid_q;
    logic                rd_valid_d;
    logic                ack_err_q;
    logic                ack_err_d;
    logic                tx_q;
    logic                tx_d;

    logic                accept;
    logic                phy_idle;
    logic                phy_act;
    logic                can_start;
    logic                settled;
    logic                done_act;
    logic                done_idle;
    logic                want_stop;
    logic                last_bit;

    assign cmd_in = pack_cmd(host.cmd_write, host.cmd_read,
                             host.cmd_nack, host.cmd_stop);

    // Held off for the release cycle after an abort.
    assign host.cmd_ready = (state_q == C_IDLE) &&
                            !pls_q.release_bus;
    assign accept    = host.cmd_valid && host.cmd_ready;

    assign phy_idle  = (phy_state == PHY_IDLE);
    assign phy_act   = (phy_state == PHY_ACTIVE);
    assign can_start = phy_idle || phy_act;
    assign settled   = (guard_q == 2'd0);
    assign done_act  = settled && phy_act;
    assign done_idle = settled && phy_idle;
    assign want_stop = cmd_q.stop && bus_control;
    assign last_bit  = (cnt_q == '0);

    assign host.rd_data  = rd_data_q;
    assign host.rd_valid = rd_valid_q;
    assign host.ack_err  = ack_err_q;

    assign phy_start_bit   = pls_q.start;
    assign phy_stop_bit    = pls_q.stop;
    assign phy_write_bit   = pls_q.write;
    assign phy_read_bit    = pls_q.read;
    assign phy_release_bus = pls_q.release_bus;
    assign phy_tx_data     = tx_q;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: issue states wait for a legal phy state,
    // wait states for completion after the guard cycle.
    always_comb begin
        state_d = state_q;
        if (host.abort) begin
            state_d = C_IDLE;
        end else begin
            unique case (state_q)
                C_IDLE: begin
                    if (accept) begin
                        if (host.cmd_start) begin
                            state_d = C_START;
                        end else if (cmd_in.op) begin
                            state_d = C_BIT;
                        end else if (cmd_in.stop && bus_control) begin
                            state_d = C_STOP;
                        end
                    end
                end
                C_START: begin
                    if (can_start) state_d = C_WAIT_START;
                end
                C_WAIT_START: begin
                    if (done_act) begin
                        if (cmd_q.op) begin
                            state_d = C_BIT;
                        end else if (want_stop) begin
                            state_d = C_STOP;
                        end else begin
                            state_d = C_IDLE;
                        end
                    end
                end
                C_BIT: begin
                    if (phy_act) state_d = C_WAIT_BIT;
                end
                C_WAIT_BIT: begin
                    if (done_act) begin
                        state_d = last_bit ? C_ACK : C_BIT;
                    end
                end
                C_ACK: begin
                    if (phy_act) state_d = C_WAIT_ACK;
                end
                C_WAIT_ACK: begin
                    if (done_act) begin
                        state_d = want_stop ? C_STOP : C_IDLE;
                    end
                end
                C_STOP: begin
                    if (phy_act) state_d = C_WAIT_STOP;
                end
                C_WAIT_STOP: begin
                    if (done_idle) state_d = C_IDLE;
                end
                default: state_d = C_IDLE;
            endcase
        end
    end

    // Outputs and datapath: pulses, shift/count, read/ACK results.
    always_comb begin
        cmd_d      = cmd_q;
        pls_d      = '0;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        cnt_d      = cnt_q;
        guard_d    = settled ? 2'd0 : guard_q - 2'd1;
        rd_valid_d = 1'b0;
        ack_err_d  = ack_err_q;
        tx_d       = tx_q;
        if (host.abort) begin
            pls_d.release_bus = 1'b1;
            cmd_d             = '0;
            guard_d           = 2'd0;
        end else begin
            unique case (state_q)
                C_IDLE: begin
                    if (accept) begin
                        cmd_d     = cmd_in;
                        shift_d   = host.cmd_data;
                        cnt_d     = CNT_TOP;
                        ack_err_d = 1'b0;
                        guard_d   = 2'd0;
                    end
                end
                C_START: begin
                    if (can_start) begin
                        pls_d.start = 1'b1;
                        guard_d     = GUARD;
                    end
                end
                C_BIT: begin
                    if (phy_act) begin
                        if (cmd_q.read) begin
                            pls_d.read  = 1'b1;
                        end else begin
                            pls_d.write = 1'b1;
                            tx_d        = shift_q[I2C_BITS-1];
                        end
                        guard_d = GUARD;
                    end
                end
                C_WAIT_BIT: begin
                    if (done_act) begin
                        shift_d = {shift_q[I2C_BITS-2:0],
                                   cmd_q.read & phy_rx_data};
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                C_ACK: begin
                    if (phy_act) begin
                        if (cmd_q.read) begin
                            pls_d.write = 1'b1;
                            tx_d        = cmd_q.nack;
                        end else begin
                            pls_d.read  = 1'b1;
                        end
                        guard_d = GUARD;
                    end
                end
                C_WAIT_ACK: begin
                    if (done_act) begin
                        if (cmd_q.read) begin
                            rd_data_d  = shift_q;
                            rd_valid_d = 1'b1;
                        end else begin
                            ack_err_d  = phy_rx_data;
                        end
                    end
                end
                C_STOP: begin
                    if (phy_act) begin
                        pls_d.stop = 1'b1;
                        guard_d    = GUARD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and registered phy pulse flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            pls_q      <= '0;
            shift_q    <= '0;
            rd_data_q  <= '0;
            cnt_q      <= CNT_TOP;
            guard_q    <= 2'd0;
            rd_valid_q <= 1'b0;
            ack_err_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            cmd_q      <= cmd_d;
            pls_q      <= pls_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            rd_valid_q <= rd_valid_d;
            ack_err_q  <= ack_err_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Self-checking bench for i2c_byte_ctrl with a behavioural
// phy/slave model and an event-list reference model.
module tb_i2c_byte_ctrl;
    import i2c_pkg::*;

    localparam logic [2:0] EV_S   = 3'd1;
    localparam logic [2:0] EV_P   = 3'd2;
    localparam logic [2:0] EV_W   = 3'd3;
    localparam logic [2:0] EV_R   = 3'd4;
    localparam logic [2:0] EV_REL = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       phy_start_bit, phy_stop_bit, phy_write_bit;
    logic       phy_read_bit, phy_release_bus, phy_tx_data;
    logic       phy_rx_data;
    logic [4:0] phy_state;
    logic       bus_control;

    i2c_byte_ctrl_if host_if ();

    i2c_byte_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .host            (host_if),
        .phy_start_bit   (phy_start_bit),
        .phy_stop_bit    (phy_stop_bit),
        .phy_write_bit   (phy_write_bit),
        .phy_read_bit    (phy_read_bit),
        .phy_release_bus (phy_release_bus),
        .phy_tx_data     (phy_tx_data),
        .phy_rx_data     (phy_rx_data),
        .phy_state       (phy_state),
        .bus_control     (bus_control)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];
    bit         slave_bits[$];
    bit         bus_held_m = 1'b0;
    int         rdv_cnt = 0;
    int         rs_cnt = 0;
    int         w_cnt = 0;
    int         r_cnt = 0;
    int         proto_err = 0;
    logic [7:0] rdv_data = 8'h00;
    int         busy_cnt;
    logic [4:0] tgt;
    logic       rx_pend;

    // Phy + slave model: each pulse keeps the phy busy for 1..4
    // cycles, then it settles in ACTIVE (or IDLE after a stop).
    always @(posedge clk) begin
        if (rst) begin
            phy_state   <= PHY_IDLE;
            bus_control <= 1'b0;
            phy_rx_data <= 1'b1;
            busy_cnt    <= 0;
            tgt         <= PHY_IDLE;
            rx_pend     <= 1'b1;
        end else if (phy_release_bus) begin
            phy_state   <= PHY_IDLE;
            bus_control <= 1'b0;
            busy_cnt    <= 0;
        end else if (phy_start_bit | phy_stop_bit |
                     phy_write_bit | phy_read_bit) begin
            if (!(phy_state == PHY_ACTIVE ||
                  (phy_start_bit && phy_state == PHY_IDLE)))
                proto_err++;
            busy_cnt  <= int'($urandom_range(1, 4));
            phy_state <= PHY_WR_A;
            tgt       <= phy_stop_bit ? PHY_IDLE : PHY_ACTIVE;
            if (phy_start_bit) bus_control <= 1'b1;
            if (phy_read_bit && slave_bits.size() > 0)
                rx_pend <= slave_bits.pop_front();
            else
                rx_pend <= 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                phy_state   <= tgt;
                phy_rx_data <= rx_pend;
                if (tgt == PHY_IDLE) bus_control <= 1'b0;
            end
        end
    end

    // Pulse log and read-strobe monitor.
    always @(posedge clk) begin
        if (!rst) begin
            if (phy_start_bit) begin
                got_q.push_back({EV_S, 1'b0});
                if (phy_state == PHY_ACTIVE) rs_cnt++;
            end
            if (phy_stop_bit)  got_q.push_back({EV_P, 1'b0});
            if (phy_write_bit) begin
                got_q.push_back({EV_W, phy_tx_data});
                w_cnt++;
            end
            if (phy_read_bit) begin
                got_q.push_back({EV_R, 1'b0});
                r_cnt++;
            end
            if (phy_release_bus) got_q.push_back({EV_REL, 1'b0});
            if (host_if.rd_valid) begin
                rdv_cnt++;
                rdv_data = host_if.rd_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference: the phy commands one byte command should produce.
    function automatic void build_exp(input bit s, input bit w,
                                      input bit r, input bit n,
                                      input bit p,
                                      input logic [7:0] d);
        bit held;
        held = bus_held_m;
        exp_q.delete();
        if (s) begin
            exp_q.push_back({EV_S, 1'b0});
            held = 1'b1;
        end
        if (r) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({EV_R, 1'b0});
            exp_q.push_back({EV_W, n});
        end else if (w) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back({EV_W, d[i]});
            exp_q.push_back({EV_R, 1'b0});
        end
        if (p && held) begin
            exp_q.push_back({EV_P, 1'b0});
            held = 1'b0;
        end
        bus_held_m = held;
    endfunction

    task automatic load_slave(input bit w, input bit r,
                              input logic [7:0] rbyte, input bit nak);
        slave_bits.delete();
        if (r) begin
            for (int i = 7; i >= 0; i--) slave_bits.push_back(rbyte[i]);
        end else if (w) begin
            slave_bits.push_back(nak);
        end
    endtask

    task automatic run_cmd(input bit s, input bit w, input bit r,
                           input bit n, input bit p,
                           input logic [7:0] d);
        got_q.delete();
        @(negedge clk);
        host_if.cmd_start = s;
        host_if.cmd_write = w;
        host_if.cmd_read  = r;
        host_if.cmd_nack  = n;
        host_if.cmd_stop  = p;
        host_if.cmd_data  = d;
        host_if.cmd_valid = 1'b1;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
        host_if.cmd_start = 1'b0;
        host_if.cmd_write = 1'b0;
        host_if.cmd_read  = 1'b0;
        host_if.cmd_stop  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!(host_if.cmd_ready && busy_cnt == 0) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (i >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout waiting for idle", tag);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (host_if.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ready got %b want 1", host_if.cmd_ready);
        end
        n_cmp++;
        if ({phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit,
             phy_release_bus} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_pulses got %b%b%b%b%b want 00000",
                     phy_start_bit, phy_stop_bit, phy_write_bit,
                     phy_read_bit, phy_release_bus);
        end
        n_cmp++;
        if (phy_tx_data !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_tx got %b want 1", phy_tx_data);
        end
        n_cmp++;
        if ({host_if.rd_data, host_if.rd_valid, host_if.ack_err}
            !== 10'h0) begin
            n_bad++;
            $display("FAIL rst_outs got rd=%h v=%b e=%b want 00/0/0",
                     host_if.rd_data, host_if.rd_valid, host_if.ack_err);
        end
    endtask

    task automatic test_write_byte();
        load_slave(1, 0, 8'h00, 0);
        build_exp(1, 1, 0, 0, 1, 8'hA5);
        run_cmd(1, 1, 0, 0, 1, 8'hA5);
        wait_done("wr");
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL wr_events count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL wr_event[%0d] got %h want %h",
                             i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (host_if.ack_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_ack_err got %b want 0", host_if.ack_err);
        end
        n_cmp++;
        if (phy_state !== PHY_IDLE) begin
            n_bad++;
            $display("FAIL wr_bus got %0d want %0d", phy_state, PHY_IDLE);
        end
    endtask

    task automatic test_read_byte();
        int rc0;
        rc0 = rdv_cnt;
        load_slave(0, 1, 8'h3C, 0);
        build_exp(1, 0, 1, 1, 1, 8'h00);
        run_cmd(1, 0, 1, 1, 1, 8'h00);
        wait_done("rd");
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL rd_events count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rd_event[%0d] got %h want %h",
                             i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (host_if.rd_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL rd_data got %h want 3c", host_if.rd_data);
        end
        n_cmp++;
        if (rdv_cnt !== rc0 + 1 || rdv_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL rd_valid got %0d strobes data %h want 1 / 3c",
                     rdv_cnt - rc0, rdv_data);
        end
    endtask

    task automatic test_slave_nack();
        logic [7:0] d;
        load_slave(1, 0, 8'h00, 1);
        build_exp(1, 1, 0, 0, 0, 8'h50);
        run_cmd(1, 1, 0, 0, 0, 8'h50);
        wait_done("nack");
        n_cmp++;
        if (host_if.ack_err !== 1'b1) begin
            n_bad++;
            $display("FAIL nack_ack_err got %b want 1", host_if.ack_err);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL nack_events count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL nack_event[%0d] got %h want %h",
                             i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (bus_control !== 1'b1) begin
            n_bad++;
            $display("FAIL nack_bus_held got %b want 1", bus_control);
        end
        d = 8'($urandom);
        load_slave(1, 0, 8'h00, 0);
        build_exp(0, 1, 0, 0, 1, d);
        run_cmd(0, 1, 0, 0, 1, d);
        n_cmp++;
        if (host_if.ack_err !== 1'b0) begin
            n_bad++;
            $display("FAIL nack_clear got %b want 0", host_if.ack_err);
        end
        wait_done("nack2");
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL nack2_events count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_repeated_start();
        logic [7:0] d;
        logic [7:0] rb;
        int         rs0;
        d  = 8'($urandom);
        rb = 8'($urandom);
        load_slave(1, 0, 8'h00, 0);
        build_exp(1, 1, 0, 0, 0, d);
        run_cmd(1, 1, 0, 0, 0, d);
        wait_done("rs1");
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL rs1_events count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
        rs0 = rs_cnt;
        load_slave(0, 1, rb, 0);
        build_exp(1, 0, 1, 0, 1, 8'h00);
        run_cmd(1, 0, 1, 0, 1, 8'h00);
        wait_done("rs2");
        n_cmp++;
        if (rs_cnt !== rs0 + 1) begin
            n_bad++;
            $display("FAIL rs_from_active got %0d want 1", rs_cnt - rs0);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL rs2_events count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rs2_event[%0d] got %h want %h",
                             i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (host_if.rd_data !== rb) begin
            n_bad++;
            $display("FAIL rs_rd_data got %h want %h",
                     host_if.rd_data, rb);
        end
    endtask

    task automatic test_random();
        bit         s, w, r, n, p, nak;
        logic [7:0] d;
        logic [7:0] rb;
        int         rc0;
        for (int k = 0; k < 30; k++) begin
            s   = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            n   = 1'($urandom_range(0, 1));
            p   = 1'($urandom_range(0, 1));
            nak = ($urandom_range(0, 3) == 0);
            d   = 8'($urandom);
            rb  = 8'($urandom);
            if (!bus_held_m && (w || r)) s = 1'b1;
            rc0 = rdv_cnt;
            load_slave(w, r, rb, nak);
            build_exp(s, w, r, n, p, d);
            run_cmd(s, w, r, n, p, d);
            wait_done("rnd");
            n_cmp++;
            if (got_q.size() !== exp_q.size()) begin
                n_bad++;
                $display("FAIL rnd%0d_events count got %0d want %0d",
                         k, got_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_cmp++;
                    if (got_q[i] !== exp_q[i]) begin
                        n_bad++;
                        $display("FAIL rnd%0d_event[%0d] got %h want %h",
                                 k, i, got_q[i], exp_q[i]);
                    end
                end
            end
            n_cmp++;
            if (host_if.ack_err !== ((w && !r) ? nak : 1'b0)) begin
                n_bad++;
                $display("FAIL rnd%0d_ack_err got %b want %b", k,
                         host_if.ack_err, (w && !r) ? nak : 1'b0);
            end
            if (r) begin
                n_cmp++;
                if (rdv_cnt !== rc0 + 1 || host_if.rd_data !== rb) begin
                    n_bad++;
                    $display("FAIL rnd%0d_rd got %h x%0d want %h x1",
                             k, host_if.rd_data, rdv_cnt - rc0, rb);
                end
            end
            n_cmp++;
            if (bus_control !== bus_held_m) begin
                n_bad++;
                $display("FAIL rnd%0d_bus got %b want %b",
                         k, bus_control, bus_held_m);
            end
        end
        n_cmp++;
        if (proto_err !== 0) begin
            n_bad++;
            $display("FAIL issue_rule got %0d violations want 0",
                     proto_err);
        end
    endtask

    task automatic test_abort();
        int i;
        int n0;
        int w0;
        int rc0;
        w0  = w_cnt;
        rc0 = rdv_cnt;
        load_slave(1, 0, 8'h00, 0);
        if (bus_held_m) run_cmd(0, 0, 0, 0, 1, 8'h00);
        if (bus_held_m) wait_done("ab_pre");
        bus_held_m = 1'b0;
        w0 = w_cnt;
        run_cmd(1, 1, 0, 0, 1, 8'hFF);
        i = 0;
        while (w_cnt < w0 + 3 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        host_if.abort = 1'b1;
        @(negedge clk);
        host_if.abort = 1'b0;
        n_cmp++;
        if ({phy_release_bus, phy_start_bit, phy_stop_bit,
             phy_write_bit, phy_read_bit} !== 5'b10000) begin
            n_bad++;
            $display("FAIL abort_pulse got rel=%b s=%b p=%b w=%b r=%b",
                     phy_release_bus, phy_start_bit, phy_stop_bit,
                     phy_write_bit, phy_read_bit);
        end
        n0 = got_q.size();
        n_cmp++;
        if (n0 !== 4) begin
            n_bad++;
            $display("FAIL abort_bits got %0d events want 4", n0);
        end
        @(negedge clk);
        n_cmp++;
        if (host_if.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready got %b want 1", host_if.cmd_ready);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (got_q.size() !== n0 + 1) begin
            n_bad++;
            $display("FAIL abort_after got %0d events want %0d",
                     got_q.size(), n0 + 1);
        end else if (got_q[n0] !== {EV_REL, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_release got %h want %h",
                     got_q[n0], {EV_REL, 1'b0});
        end
        n_cmp++;
        if (rdv_cnt !== rc0) begin
            n_bad++;
            $display("FAIL abort_rd_valid got %0d want 0", rdv_cnt - rc0);
        end
        slave_bits.delete();
        bus_held_m = 1'b0;
    endtask

    task automatic test_rst_mid_read();
        int i;
        int r0;
        int rc0;
        r0  = r_cnt;
        rc0 = rdv_cnt;
        load_slave(0, 1, 8'($urandom), 0);
        run_cmd(1, 0, 1, 0, 1, 8'h00);
        i = 0;
        while (r_cnt < r0 + 2 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (host_if.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mrst_ready got %b want 1", host_if.cmd_ready);
        end
        n_cmp++;
        if ({phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit,
             phy_release_bus, phy_tx_data} !== 6'b000001) begin
            n_bad++;
            $display("FAIL mrst_phy got %b%b%b%b%b tx=%b want 00000 tx=1",
                     phy_start_bit, phy_stop_bit, phy_write_bit,
                     phy_read_bit, phy_release_bus, phy_tx_data);
        end
        n_cmp++;
        if ({host_if.rd_data, host_if.rd_valid, host_if.ack_err}
            !== 10'h0) begin
            n_bad++;
            $display("FAIL mrst_outs got rd=%h v=%b e=%b want 00/0/0",
                     host_if.rd_data, host_if.rd_valid, host_if.ack_err);
        end
        got_q.delete();
        repeat (30) @(negedge clk);
        n_cmp++;
        if (got_q.size() !== 0 || rdv_cnt !== rc0) begin
            n_bad++;
            $display("FAIL mrst_quiet got %0d events %0d strobes want 0/0",
                     got_q.size(), rdv_cnt - rc0);
        end
        slave_bits.delete();
        bus_held_m = 1'b0;
    endtask

    initial begin
        host_if.cmd_valid = 1'b0;
        host_if.cmd_start = 1'b0;
        host_if.cmd_write = 1'b0;
        host_if.cmd_read  = 1'b0;
        host_if.cmd_nack  = 1'b0;
        host_if.cmd_stop  = 1'b0;
        host_if.cmd_data  = 8'h00;
        host_if.abort     = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_write_byte();
        test_read_byte();
        test_slave_nack();
        test_repeated_start();
        test_random();
        test_abort();
        test_rst_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
